// File: rtl/async_queue_pkg.sv
// ----------------------------------------------------------------------------
// async_queue_pkg : shared sizing and Gray helper for the async queue sink
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package async_queue_pkg;

  localparam int WIDTH = 15;
  localparam int DEPTH = 8;
  localparam int SYNC  = 3;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_shift_reg_w4.sv
// ----------------------------------------------------------------------------
// sync_shift_reg_w4 : multi-stage synchronizer for a 4-bit Gray pointer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_shift_reg_w4
  import async_queue_pkg::*;
#(
  parameter int STAGES = async_queue_pkg::SYNC
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [PTR_W-1:0] d,
  output logic [PTR_W-1:0] q
);

  logic [STAGES-1:0][PTR_W-1:0] stages_q;
  logic [STAGES-1:0][PTR_W-1:0] stages_d;

  always_comb begin
    stages_d    = stages_q;
    stages_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      stages_d[i] = stages_q[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stages_q <= '0;
    end else begin
      stages_q <= stages_d;
    end
  end

  assign q = stages_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/async_queue_sink_w15.sv
// ----------------------------------------------------------------------------
// async_queue_sink_w15 : sink half of a Gray-pointer asynchronous queue
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module async_queue_sink_w15
  import async_queue_pkg::*;
#(
  parameter int WIDTH = async_queue_pkg::WIDTH,
  parameter int DEPTH = async_queue_pkg::DEPTH,
  parameter int SYNC  = async_queue_pkg::SYNC
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH*DEPTH-1:0] io_async_mem,
  input  logic [PTR_W-1:0]       io_async_widx,
  output logic [PTR_W-1:0]       io_async_ridx,
  output logic                   io_deq_valid,
  output logic [WIDTH-1:0]       io_deq_bits,
  input  logic                   io_deq_ready
);

  localparam int AW = $clog2(DEPTH);

  logic [PTR_W-1:0] widx_s;
  logic [PTR_W-1:0] ridx_q,      ridx_d;
  logic [PTR_W-1:0] ridx_gray_q, ridx_gray_d;
  logic             valid_q,     valid_d;
  logic [WIDTH-1:0] bits_q,      bits_d;
  logic [PTR_W-1:0] ridx_next;
  logic             transfer;
  logic             empty;
  logic [WIDTH-1:0] mem_entry [DEPTH];

  sync_shift_reg_w4 #(
    .STAGES (SYNC)
  ) u_widx_sync (
    .clock (clock),
    .reset (reset),
    .d     (io_async_widx),
    .q     (widx_s)
  );

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem_unpack
      assign mem_entry[gi] = io_async_mem[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Empty is judged against the post-transfer pointer so a queued entry
  // follows the consumed one without a bubble.
  always_comb begin
    transfer    = valid_q & io_deq_ready;
    ridx_next   = ridx_q + {{(PTR_W-1){1'b0}}, transfer};
    empty       = (bin2gray(ridx_next) == widx_s);
    ridx_d      = ridx_next;
    ridx_gray_d = bin2gray(ridx_next);
    valid_d     = !empty;
    bits_d      = bits_q;
    if (!empty) begin
      bits_d = mem_entry[ridx_next[AW-1:0]];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ridx_q      <= '0;
      ridx_gray_q <= '0;
      valid_q     <= 1'b0;
      bits_q      <= '0;
    end else begin
      ridx_q      <= ridx_d;
      ridx_gray_q <= ridx_gray_d;
      valid_q     <= valid_d;
      bits_q      <= bits_d;
    end
  end

  assign io_async_ridx = ridx_gray_q;
  assign io_deq_valid  = valid_q;
  assign io_deq_bits   = bits_q;

endmodule

`default_nettype wire
